// File: rtl/round_ctrl.sv
// ---------------------------------------------------------------------------
// round_ctrl
//   Reaction-round sequencer placed downstream of a 16-bit elapsed-time
//   counter. It gates the counter's count-enable with the 8 Hz tick and pulses
//   the counter's synchronous clear. It waits 2 s (sec_2), arms the player cue,
//   then either captures the elapsed count when stop is pressed or times out
//   at 4 s (sec_4). A stop press during the 2 s wait is a foul. Valid captures
//   are tallied in a saturating win counter.
//
// Ports
//   clk        in   system clock, all state on rising edge
//   reset_n    in   asynchronous active-low reset
//   tick       in   1-cycle 8 Hz strobe from the tick generator
//   go_btn     in   raw start button (asynchronous level)
//   stop_btn   in   raw stop button (asynchronous level)
//   time_bits  in   elapsed count from the time counter
//   sec_2      in   time counter bit4 (>= 2 s since clear)
//   sec_4      in   time counter bit5 (>= 4 s since clear)
//   count      out  count-enable to the time counter (combinational)
//   timer_clr  out  one-cycle synchronous clear to the time counter
//   armed      out  player cue, high while waiting for stop
//   foul       out  stop was pressed before the cue
//   timeout    out  no stop within 4 s of the cue
//   result     out  last captured reaction count
//   wins       out  number of valid captures, saturating
// ---------------------------------------------------------------------------
module round_ctrl #(
  parameter int TIME_W = 16,
  parameter int WINS_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              go_btn,
  input  logic              stop_btn,
  input  logic [TIME_W-1:0] time_bits,
  input  logic              sec_2,
  input  logic              sec_4,
  output logic              count,
  output logic              timer_clr,
  output logic              armed,
  output logic              foul,
  output logic              timeout,
  output logic [TIME_W-1:0] result,
  output logic [WINS_W-1:0] wins
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLR1    = 3'd1;
  localparam logic [2:0] S_DELAY   = 3'd2;
  localparam logic [2:0] S_CLR2    = 3'd3;
  localparam logic [2:0] S_ARMED   = 3'd4;
  localparam logic [2:0] S_SHOW    = 3'd5;
  localparam logic [2:0] S_FOUL    = 3'd6;
  localparam logic [2:0] S_TIMEOUT = 3'd7;

  logic [2:0] state;
  logic [2:0] next_state;

  // Button synchronizers: two flops for metastability, a third holds the
  // previous synchronized level for rising-edge detection.
  logic go_s1, go_s2, go_s3;
  logic stop_s1, stop_s2, stop_s3;

  // Counts the cycles after reset until the synchronizer pipeline holds real
  // pad levels. Edges are suppressed until then, so a button already held
  // while reset is released does not look like a fresh press.
  logic [1:0] settle;
  logic       primed;
  logic       go_p;
  logic       stop_p;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      go_s1   <= 1'b0;
      go_s2   <= 1'b0;
      go_s3   <= 1'b0;
      stop_s1 <= 1'b0;
      stop_s2 <= 1'b0;
      stop_s3 <= 1'b0;
      settle  <= 2'd0;
    end else begin
      go_s1   <= go_btn;
      go_s2   <= go_s1;
      go_s3   <= go_s2;
      stop_s1 <= stop_btn;
      stop_s2 <= stop_s1;
      stop_s3 <= stop_s2;
      if (settle != 2'b11) begin
        settle <= settle + 2'd1;
      end
    end
  end

  assign primed = &settle;
  assign go_p   = go_s2 & ~go_s3 & primed;
  assign stop_p = stop_s2 & ~stop_s3 & primed;

  // Count-enable has no register stage so the counter advances on the same
  // edge the tick is presented.
  assign count = tick & ((state == S_DELAY) | (state == S_ARMED)) & ~timer_clr;

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned; otherwise a latch would be inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (go_p) next_state = S_CLR1;
      S_CLR1:    next_state = S_DELAY;
      S_DELAY: begin
        if (stop_p)     next_state = S_FOUL;
        else if (sec_2) next_state = S_CLR2;
      end
      S_CLR2:    next_state = S_ARMED;
      S_ARMED: begin
        if (stop_p)     next_state = S_SHOW;
        else if (sec_4) next_state = S_TIMEOUT;
      end
      S_SHOW:    if (go_p) next_state = S_CLR1;
      S_FOUL:    if (go_p) next_state = S_CLR1;
      S_TIMEOUT: if (go_p) next_state = S_CLR1;
      default:   next_state = S_IDLE;
    endcase
  end

  // Status outputs are decoded from next_state into flops so they line up
  // exactly with the state register and never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      timer_clr <= 1'b0;
      armed     <= 1'b0;
      foul      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= next_state;
      timer_clr <= (next_state == S_CLR1) | (next_state == S_CLR2);
      armed     <= (next_state == S_ARMED);
      foul      <= (next_state == S_FOUL);
      timeout   <= (next_state == S_TIMEOUT);
    end
  end

  // Capture happens on the same edge that leaves ARMED for SHOW; stop has
  // priority over sec_4, so a simultaneous arrival still counts as a win.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      wins   <= '0;
    end else if ((state == S_ARMED) && stop_p) begin
      result <= time_bits;
      if (wins != {WINS_W{1'b1}}) begin
        wins <= wins + WINS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_round_ctrl
//   Self-checking bench for round_ctrl. A behavioural elapsed-time counter
//   closes the loop (cleared by timer_clr, advanced by count, bit4/bit5 fed
//   back as sec_2/sec_4). Each round's outcome (win, foul, timeout) is chosen
//   up front and the expected result/wins/flags follow from the round rules:
//   a win captures the number of ticks since the cue, wins saturate at 15.
// ---------------------------------------------------------------------------
module tb_round_ctrl;

  localparam int K_VALID   = 0;
  localparam int K_FOUL    = 1;
  localparam int K_TIMEOUT = 2;
  localparam int K_SIMUL   = 3;
  localparam int WINS_MAX  = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic        go_btn = 1'b0;
  logic        stop_btn = 1'b0;
  logic [15:0] tc;
  logic        count, timer_clr, armed, foul, timeout;
  logic [15:0] result;
  logic [3:0]  wins;

  int n_checks = 0;
  int n_errors = 0;
  int exp_result = 0;
  int exp_wins = 0;
  int captures = 0;

  int   clr_cnt = 0;
  int   long_clr = 0;
  int   count_in_foul = 0;
  logic prev_clr = 1'b0;

  round_ctrl #(.TIME_W(16), .WINS_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .go_btn    (go_btn),
    .stop_btn  (stop_btn),
    .time_bits (tc),
    .sec_2     (tc[4]),
    .sec_4     (tc[5]),
    .count     (count),
    .timer_clr (timer_clr),
    .armed     (armed),
    .foul      (foul),
    .timeout   (timeout),
    .result    (result),
    .wins      (wins)
  );

  always #5 clk = ~clk;

  // Elapsed-time counter seen by the sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       tc <= '0;
    else if (timer_clr) tc <= '0;
    else if (count)     tc <= tc + 16'd1;
  end

  // 8-cycle tick period keeps a button press (3 clk latency) well inside one
  // tick interval.
  initial begin
    forever begin
      repeat (7) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (timer_clr)            clr_cnt <= clr_cnt + 1;
    if (timer_clr && prev_clr) long_clr <= long_clr + 1;
    if (foul && count)        count_in_foul <= count_in_foul + 1;
    prev_clr <= timer_clr;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return armed;
      1:       return timer_clr;
      default: return timeout;
    endcase
  endfunction

  task automatic wait_on(input string tag, input int which, input int budget);
    int   i = 0;
    logic hit;
    hit = pick(which);
    while (!hit && i < budget) begin
      @(negedge clk);
      i++;
      hit = pick(which);
    end
    if (!hit) check(tag, hit, 1);
  endtask

  task automatic wait_tc(input string tag, input int k, input int budget);
    int i = 0;
    while (int'(tc) != k && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (int'(tc) != k) check(tag, tc, k);
  endtask

  // A press holds the pad for four cycles; the edge-detected pulse acts on
  // the third rising edge, so the DUT has reacted by the time this returns.
  task automatic press_go();
    @(negedge clk);
    go_btn = 1'b1;
    repeat (4) @(negedge clk);
    go_btn = 1'b0;
  endtask

  task automatic press_stop();
    @(negedge clk);
    stop_btn = 1'b1;
    repeat (4) @(negedge clk);
    stop_btn = 1'b0;
  endtask

  task automatic add_win(input int captured);
    exp_result = captured;
    exp_wins   = (exp_wins < WINS_MAX) ? exp_wins + 1 : WINS_MAX;
    captures++;
  endtask

  task automatic do_round(input int kind, input int k, input bit inject);
    int c0, lc0, f0;
    c0  = clr_cnt;
    lc0 = long_clr;
    press_go();
    if (kind == K_FOUL) begin
      wait_tc("foul_wait", k, 160);
      press_stop();
      check("foul_flag", foul, 1);
      check("foul_result", result, exp_result);
      check("foul_wins", wins, exp_wins);
      check("foul_clr_pulses", clr_cnt - c0, 1);
      f0 = count_in_foul;
      repeat (24) @(negedge clk);
      check("foul_count_off", count_in_foul - f0, 0);
    end else begin
      if (inject) begin
        wait_tc("inject_wait", 3, 60);
        press_go();
      end
      wait_on("armed_wait", 0, 200);
      if (kind == K_TIMEOUT) begin
        wait_on("timeout_wait", 2, 300);
        check("timeout_armed", armed, 0);
      end else if (kind == K_SIMUL) begin
        wait_tc("simul_wait", 31, 300);
        repeat (5) @(negedge clk);
        press_stop();
        add_win(32);
      end else begin
        wait_tc("valid_wait", k, 300);
        press_stop();
        add_win(k);
      end
      check("round_timeout", timeout, (kind == K_TIMEOUT) ? 1 : 0);
      check("round_foul", foul, 0);
      check("round_armed", armed, 0);
      check("round_result", result, exp_result);
      check("round_wins", wins, exp_wins);
      check("round_clr_pulses", clr_cnt - c0, 2);
    end
    check("clr_width", long_clr - lc0, 0);
  endtask

  initial begin
    int c0;
    // Reset with both buttons held.
    go_btn   = 1'b1;
    stop_btn = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_timer_clr", timer_clr, 0);
    check("rst_armed", armed, 0);
    check("rst_foul", foul, 0);
    check("rst_timeout", timeout, 0);
    check("rst_result", result, 0);
    check("rst_wins", wins, 0);
    c0 = clr_cnt;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("held_go_ignored", clr_cnt - c0, 0);
    check("held_stop_no_foul", foul, 0);
    go_btn   = 1'b0;
    stop_btn = 1'b0;
    repeat (4) @(negedge clk);

    // Directed rounds.
    do_round(K_VALID, 10, 1'b0);
    do_round(K_FOUL, 5, 1'b0);
    do_round(K_TIMEOUT, 0, 1'b0);
    do_round(K_SIMUL, 0, 1'b0);
    do_round(K_VALID, 31, 1'b1);

    // Random rounds.
    for (int r = 0; r < 14; r++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == K_FOUL) do_round(kind, int'($urandom_range(0, 15)), 1'b0);
      else                do_round(kind, int'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));
    end

    // Push the win tally past saturation.
    while (captures < 17) begin
      do_round(K_VALID, int'($urandom_range(1, 31)), 1'b0);
    end

    // Asynchronous reset while armed, between clock edges.
    press_go();
    wait_on("armed_wait_rst", 0, 200);
    wait_tc("rst_armed_wait", 5, 100);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    exp_result = 0;
    exp_wins   = 0;
    check("async_armed", armed, 0);
    check("async_result", result, exp_result);
    check("async_wins", wins, exp_wins);
    check("async_count", count, 0);
    check("async_timer_clr", timer_clr, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    c0 = clr_cnt;
    press_stop();
    repeat (4) @(negedge clk);
    check("idle_stop_result", result, exp_result);
    check("idle_stop_foul", foul, 0);
    check("idle_stop_clr", clr_cnt - c0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
